dsp_rms_meter: RTL and testbench

Multi-channel windowed RMS and peak meter for the audio path. It accumulates the square of every sample per channel over a block-power window of 2^LOG_WIN samples and averages it. A single shared iterative square root converts each window's mean square to an RMS magnitude. It replaces the single-channel, fixed-window power-to-SRC stage by adding a channel count parameter, window length parameter, peak hold, and overrun flagging, and it sits between the audio input stage and the visualisation/AGC logic.

---
 rtl/dsp_rms_meter_pkg.sv | 20 ++
 rtl/int_sqrt_iter.sv | 65 ++++++
 rtl/dsp_rms_meter.sv | 186 ++++++++++++++++++
 tb/tb_dsp_rms_meter.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/dsp_rms_meter_pkg.sv
// Shared audio-path definitions for the RMS/peak meter: sample width, sqrt FSM states
// and an index-width helper.
package dsp_rms_meter_pkg;

    localparam int unsigned AUDIO_WS = 16;

    typedef logic signed [AUDIO_WS-1:0] audio_t;

    typedef enum logic [1:0] {
        StIdle,
        StCalc,
        StDone
    } sqrt_state_e;

    // Channel index width; a single channel still needs one select bit.
    function automatic int unsigned clog2_min1(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/int_sqrt_iter.sv
// Restoring bit-serial integer square root: floor(sqrt(radicand)), one root bit per cycle
// MSB first. The first bit is resolved on the start edge; done pulses when root is final.
module int_sqrt_iter #(
    parameter int unsigned WS = 16
) (
    input  logic            iCLK,
    input  logic            iRST_N,
    input  logic [2*WS-1:0] radicand,
    input  logic            start,
    output logic [WS-1:0]   root,
    output logic            done
);

    localparam int unsigned CNTW = $clog2(WS + 1);

    logic [2*WS-1:0] rad_q, rad_src;
    logic [WS:0]     rem_q, rem_src, rem_d;
    logic [WS-1:0]   root_q, root_src, root_d;
    logic [WS+2:0]   r2, trial;
    logic [CNTW-1:0] cnt_q;
    logic            done_q;

    always_comb begin
        rad_src  = start ? radicand : rad_q;
        rem_src  = start ? '0 : rem_q;
        root_src = start ? '0 : root_q;
        r2       = {rem_src, rad_src[2*WS-1 -: 2]};
        trial    = {1'b0, root_src, 2'b01};
        if (r2 >= trial) begin
            rem_d  = (WS + 1)'(r2 - trial);
            root_d = WS'({root_src, 1'b1});
        end else begin
            rem_d  = (WS + 1)'(r2);
            root_d = WS'({root_src, 1'b0});
        end
    end

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            rad_q  <= '0;
            rem_q  <= '0;
            root_q <= '0;
            cnt_q  <= '0;
            done_q <= 1'b0;
        end else if (start) begin
            rad_q  <= (2 * WS)'({rad_src, 2'b00});
            rem_q  <= rem_d;
            root_q <= root_d;
            cnt_q  <= CNTW'(WS - 1);
            done_q <= (WS == 1);
        end else if (cnt_q != '0) begin
            rad_q  <= (2 * WS)'({rad_src, 2'b00});
            rem_q  <= rem_d;
            root_q <= root_d;
            cnt_q  <= cnt_q - CNTW'(1);
            done_q <= (cnt_q == CNTW'(1));
        end else begin
            done_q <= 1'b0;
        end
    end

    assign root = root_q;
    assign done = done_q;

endmodule

// File: rtl/dsp_rms_meter.sv
// Multi-channel windowed RMS and peak meter: per-channel sum of squares over 2^LOG_WIN
// samples, one shared iterative sqrt serving completed windows in channel-priority order.
module dsp_rms_meter
    import dsp_rms_meter_pkg::*;
#(
    parameter int unsigned WS      = AUDIO_WS,
    parameter int unsigned CH      = 2,
    parameter int unsigned LOG_WIN = 12,
    parameter int unsigned CW      = clog2_min1(CH)
) (
    input  logic          iCLK,
    input  logic          iRST_N,
    input  logic [WS-1:0] iIn,
    input  logic [CW-1:0] iCh,
    input  logic          iValid,
    output logic [WS-1:0] oRms,
    output logic [WS-1:0] oPeak,
    output logic [CW-1:0] oRmsCh,
    output logic          oValid,
    output logic          oBusy,
    output logic          oOvf
);

    localparam int unsigned AW = 2 * WS + LOG_WIN - 1;
    localparam int unsigned MW = 2 * WS;

    logic [AW-1:0]      acc_q   [CH];
    logic [LOG_WIN-1:0] cnt_q   [CH];
    logic [WS-1:0]      peak_q  [CH];
    logic [WS-1:0]      lpeak_q [CH];
    logic [MW-1:0]      mean_q  [CH];
    logic [CH-1:0]      pend_q;

    sqrt_state_e state_q;
    logic [CW-1:0] cur_ch_q;
    logic [WS-1:0] cur_peak_q;

    logic                accept, win_close, pend_cur, take_cur, ovf_set, start, sq_done;
    logic signed [MW-1:0] in_ext, sq_s;
    logic [MW-1:0]       sq, mean_new, sel_mean;
    logic [WS-1:0]       mag, peak_cur, peak_new, sel_peak, root;
    logic [AW-1:0]       acc_cur, acc_sum;
    logic [LOG_WIN-1:0]  cnt_cur;
    logic [CH-1:0]       hit, take;
    logic [CW-1:0]       sel;

    assign accept = iValid && (32'(iCh) < CH);
    assign in_ext = {{WS{iIn[WS-1]}}, iIn};
    assign sq_s   = in_ext * in_ext;
    assign sq     = $unsigned(sq_s);
    // Two's-complement negate; the most negative sample maps to 2^(WS-1) as unsigned.
    assign mag    = iIn[WS-1] ? (~iIn + WS'(1)) : iIn;
    assign start  = (state_q == StIdle) && (|pend_q);

    always_comb begin
        hit      = '0;
        take     = '0;
        acc_cur  = '0;
        cnt_cur  = '0;
        peak_cur = '0;
        pend_cur = 1'b0;
        sel      = '0;
        sel_mean = '0;
        sel_peak = '0;
        for (int c = 0; c < CH; c++) begin
            if (accept && (iCh == CW'(c))) begin
                hit[c]   = 1'b1;
                acc_cur  = acc_q[c];
                cnt_cur  = cnt_q[c];
                peak_cur = peak_q[c];
                pend_cur = pend_q[c];
            end
        end
        // Priority encoder: lowest pending index wins.
        for (int c = int'(CH) - 1; c >= 0; c--) begin
            if (pend_q[c]) begin
                sel      = CW'(c);
                sel_mean = mean_q[c];
                sel_peak = lpeak_q[c];
            end
        end
        for (int c = 0; c < CH; c++) begin
            take[c] = start && (sel == CW'(c));
        end
    end

    assign acc_sum   = acc_cur + AW'(sq);
    assign peak_new  = (mag > peak_cur) ? mag : peak_cur;
    assign mean_new  = MW'(acc_sum >> LOG_WIN);
    assign win_close = accept && (&cnt_cur);
    assign take_cur  = |(hit & take);
    // A close on the channel being taken this cycle refills pending without loss.
    assign ovf_set   = win_close && pend_cur && !take_cur;

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            for (int c = 0; c < CH; c++) begin
                acc_q[c]   <= '0;
                cnt_q[c]   <= '0;
                peak_q[c]  <= '0;
                lpeak_q[c] <= '0;
                mean_q[c]  <= '0;
            end
            pend_q <= '0;
            oOvf   <= 1'b0;
        end else begin
            for (int c = 0; c < CH; c++) begin
                if (hit[c]) begin
                    if (win_close) begin
                        mean_q[c]  <= mean_new;
                        lpeak_q[c] <= peak_new;
                        acc_q[c]   <= '0;
                        cnt_q[c]   <= '0;
                        peak_q[c]  <= '0;
                    end else begin
                        acc_q[c]  <= acc_sum;
                        cnt_q[c]  <= cnt_cur + LOG_WIN'(1);
                        peak_q[c] <= peak_new;
                    end
                end
                if (hit[c] && win_close) begin
                    pend_q[c] <= 1'b1;
                end else if (take[c]) begin
                    pend_q[c] <= 1'b0;
                end
            end
            if (ovf_set) begin
                oOvf <= 1'b1;
            end
        end
    end

    int_sqrt_iter #(
        .WS(WS)
    ) u_sqrt (
        .iCLK    (iCLK),
        .iRST_N  (iRST_N),
        .radicand(sel_mean),
        .start   (start),
        .root    (root),
        .done    (sq_done)
    );

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            state_q    <= StIdle;
            cur_ch_q   <= '0;
            cur_peak_q <= '0;
            oRms       <= '0;
            oPeak      <= '0;
            oRmsCh     <= '0;
            oValid     <= 1'b0;
            oBusy      <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    oValid <= 1'b0;
                    if (start) begin
                        cur_ch_q   <= sel;
                        cur_peak_q <= sel_peak;
                        state_q    <= StCalc;
                        oBusy      <= 1'b1;
                    end
                end
                StCalc: begin
                    if (sq_done) begin
                        oRms    <= root;
                        oPeak   <= cur_peak_q;
                        oRmsCh  <= cur_ch_q;
                        oValid  <= 1'b1;
                        state_q <= StDone;
                    end
                end
                StDone: begin
                    oValid  <= 1'b0;
                    oBusy   <= 1'b0;
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dsp_rms_meter.sv
// Directed bench for dsp_rms_meter: a 16-sample-window instance and a 2-sample-window
// instance driven from one sequence, results captured on oValid and checked by hand values.
module tb_dsp_rms_meter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    logic [15:0] a_in;
    logic [1:0]  a_ch;
    logic        a_valid;
    logic [15:0] a_rms, a_peak;
    logic [1:0]  a_rch;
    logic        a_ovalid, a_busy, a_ovf;

    logic [15:0] b_in;
    logic        b_ch;
    logic        b_valid;
    logic [15:0] b_rms, b_peak;
    logic        b_rch;
    logic        b_ovalid, b_busy, b_ovf;

    dsp_rms_meter #(
        .WS(16), .CH(2), .LOG_WIN(4), .CW(2)
    ) dut_a (
        .iCLK(clk), .iRST_N(rst_n), .iIn(a_in), .iCh(a_ch), .iValid(a_valid),
        .oRms(a_rms), .oPeak(a_peak), .oRmsCh(a_rch), .oValid(a_ovalid),
        .oBusy(a_busy), .oOvf(a_ovf)
    );

    dsp_rms_meter #(
        .WS(16), .CH(2), .LOG_WIN(1)
    ) dut_b (
        .iCLK(clk), .iRST_N(rst_n), .iIn(b_in), .iCh(b_ch), .iValid(b_valid),
        .oRms(b_rms), .oPeak(b_peak), .oRmsCh(b_rch), .oValid(b_ovalid),
        .oBusy(b_busy), .oOvf(b_ovf)
    );

    typedef struct {
        int rms;
        int peak;
        int ch;
        int cyc;
    } res_t;

    res_t qa[$];
    res_t qb[$];
    int   cyc = 0;
    int   n_assert = 0;
    int   n_fail = 0;
    int   last_a = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        res_t r;
        if (a_ovalid) begin
            r.rms = int'(a_rms); r.peak = int'(a_peak); r.ch = int'(a_rch); r.cyc = cyc;
            qa.push_back(r);
        end
        if (b_ovalid) begin
            r.rms = int'(b_rms); r.peak = int'(b_peak); r.ch = int'(b_rch); r.cyc = cyc;
            qb.push_back(r);
        end
    end

    task automatic check(input string tag, input longint obs, input longint exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic send_a(input int ch, input int val);
        @(negedge clk);
        a_ch    = 2'(ch);
        a_in    = 16'(val);
        a_valid = 1'b1;
        last_a  = cyc;
    endtask

    task automatic send_b(input int val);
        @(negedge clk);
        b_ch    = 1'b0;
        b_in    = 16'(val);
        b_valid = 1'b1;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            a_valid = 1'b0;
            b_valid = 1'b0;
        end
    endtask

    task automatic get_a(input string tag, input int maxc, output res_t r);
        int k = 0;
        r.rms = -1; r.peak = -1; r.ch = -1; r.cyc = -1;
        while (qa.size() == 0 && k < maxc) begin
            @(negedge clk);
            #1;
            k++;
        end
        check({tag, " result timeout"}, longint'(qa.size() > 0), 1);
        if (qa.size() > 0) r = qa.pop_front();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        res_t r, r0;
        int nv;
        rst_n = 1'b0;
        a_valid = 1'b0; a_in = '0; a_ch = '0;
        b_valid = 1'b0; b_in = '0; b_ch = 1'b0;
        repeat (3) @(negedge clk);
        check("reset rms", a_rms, 0);
        check("reset peak", a_peak, 0);
        check("reset ch", a_rch, 0);
        check("reset valid", a_ovalid, 0);
        check("reset busy", a_busy, 0);
        check("reset ovf", a_ovf, 0);
        rst_n = 1'b1;
        idle(2);

        // Constant 1000 on ch0: latency from last sample to strobe is 18 cycles.
        for (int i = 0; i < 16; i++) send_a(0, 1000);
        idle(3);
        check("busy during calc", a_busy, 1);
        get_a("s1", 40, r);
        check("s1 latency", r.cyc, last_a + 18);
        check("s1 rms", r.rms, 1000);
        check("s1 peak", r.peak, 1000);
        check("s1 ch", r.ch, 0);
        idle(3);
        check("s1 rms held", a_rms, 1000);

        // Full-scale extremes on ch1.
        for (int i = 0; i < 8; i++) send_a(1, -32768);
        for (int i = 0; i < 8; i++) send_a(1, 32767);
        idle(1);
        get_a("s2", 40, r);
        check("s2 rms", r.rms, 32767);
        check("s2 peak", r.peak, 32768);
        check("s2 ch", r.ch, 1);

        // Interleaved channels closing on consecutive cycles.
        for (int i = 0; i < 16; i++) begin
            send_a(0, 3);
            send_a(1, -4);
        end
        idle(1);
        get_a("s3 ch0", 40, r0);
        check("s3 ch0 latency", r0.cyc, last_a - 1 + 18);
        check("s3 ch0 rms", r0.rms, 3);
        check("s3 ch0 peak", r0.peak, 3);
        check("s3 ch0 ch", r0.ch, 0);
        get_a("s3 ch1", 40, r);
        check("s3 spacing", r.cyc, r0.cyc + 18);
        check("s3 ch1 rms", r.rms, 4);
        check("s3 ch1 peak", r.peak, 4);
        check("s3 ch1 ch", r.ch, 1);
        check("s3 no ovf", a_ovf, 0);

        // Two-sample windows arriving faster than the sqrt can drain them.
        check("s4 ovf before", b_ovf, 0);
        for (int i = 0; i < 4; i++) begin
            send_b(100);
            send_b(200);
        end
        idle(1);
        check("s4 ovf by window 4", b_ovf, 1);
        idle(60);
        check("s4 result count", qb.size(), 2);
        while (qb.size() > 0) begin
            r = qb.pop_front();
            check("s4 rms", r.rms, 158);
            check("s4 peak", r.peak, 200);
            check("s4 ch", r.ch, 0);
        end

        // Reset in the middle of a calculation.
        for (int i = 0; i < 16; i++) send_a(0, 9);
        idle(5);
        check("s5 busy before reset", a_busy, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("s5 rms cleared", a_rms, 0);
        check("s5 peak cleared", a_peak, 0);
        check("s5 ch cleared", a_rch, 0);
        check("s5 valid cleared", a_ovalid, 0);
        check("s5 busy cleared", a_busy, 0);
        qa.delete();
        qb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        idle(30);
        check("s5 no aborted result", qa.size(), 0);
        for (int i = 0; i < 16; i++) send_a(0, 50);
        idle(1);
        get_a("s5", 40, r);
        check("s5 rms", r.rms, 50);
        check("s5 peak", r.peak, 50);
        check("s5 latency", r.cyc, last_a + 18);

        // Out-of-range channel samples must be ignored entirely.
        nv = 0;
        for (int s = 0; nv < 15; s++) begin
            if (s % 4 == 3) send_a(3, 30000);
            else begin
                send_a(0, 7);
                nv++;
            end
        end
        idle(25);
        check("s6 no early result", qa.size(), 0);
        send_a(0, 7);
        idle(1);
        get_a("s6", 40, r);
        check("s6 latency", r.cyc, last_a + 18);
        check("s6 rms", r.rms, 7);
        check("s6 peak", r.peak, 7);
        check("s6 ch", r.ch, 0);
        check("s6 no ovf", a_ovf, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
